// File: rtl/uart_lite_slave.sv
// AXI4-Lite UART peripheral: 8N1 TX/RX with FIFOs, STAT/CTRL registers.
// Optional interrupt output enabled by defining UART_INTR_EN.
module uart_lite_slave #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned FIFO_DEPTH   = 16
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [3:0]  AWADDR,
  input  logic        AWVALID,
  output logic        AWREADY,
  input  logic [31:0] WDATA,
  input  logic [3:0]  WSTRB,
  input  logic        WVALID,
  output logic        WREADY,
  output logic [1:0]  BRESP,
  output logic        BVALID,
  input  logic        BREADY,
  input  logic [3:0]  ARADDR,
  input  logic        ARVALID,
  output logic        ARREADY,
  output logic [31:0] RDATA,
  output logic [1:0]  RRESP,
  output logic        RVALID,
  input  logic        RREADY,
  input  logic        RXD,
  output logic        TXD
`ifdef UART_INTR_EN
  ,
  output logic        INTERRUPT
`endif
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  // AXI handshake registers
  logic        r_awready, r_bvalid, r_arready, r_rvalid;
  logic [31:0] r_rdata;
  logic        w_wr_fire, w_rd_fire;

  // FIFO storage and pointers
  logic [7:0]  r_tx_mem [FIFO_DEPTH];
  logic [7:0]  r_rx_mem [FIFO_DEPTH];
  logic [AW:0] r_tx_wr, r_tx_rd, r_rx_wr, r_rx_rd;
  logic        w_tx_empty, w_tx_full, w_rx_valid, w_rx_full;
  logic        w_tx_push, w_tx_pop, w_tx_flush;
  logic        w_rx_push, w_rx_pop, w_rx_flush;

  // serial engines
  state_t      r_tx_state, r_rx_state;
  logic [CW-1:0] r_tx_cnt, r_rx_cnt;
  logic [2:0]  r_tx_bitn, r_rx_bitn;
  logic [7:0]  r_tx_shreg, r_rx_shreg;
  logic        r_txd;
  logic        r_rx_s1, r_rx_s2, r_rx_s3;
  logic        w_tx_tick, w_rx_tick, w_rx_stop_smp;

  logic        r_ovr, r_ferr, w_ovr_set, w_ferr_set, w_stat_clr;
  logic        w_intr_bit;
  logic [31:0] w_stat;
  logic        w_unused;

  assign w_unused = ^{WDATA[31:8], WSTRB[3:1], AWADDR[1:0], ARADDR[1:0]};

  assign AWREADY = r_awready;
  assign WREADY  = r_awready;
  assign BVALID  = r_bvalid;
  assign BRESP   = '0;
  assign ARREADY = r_arready;
  assign RVALID  = r_rvalid;
  assign RDATA   = r_rdata;
  assign RRESP   = '0;
  assign TXD     = r_txd;

  assign w_wr_fire = r_awready & AWVALID & WVALID;
  assign w_rd_fire = r_arready & ARVALID;

  assign w_tx_empty = (r_tx_wr == r_tx_rd);
  assign w_tx_full  = (r_tx_wr[AW] != r_tx_rd[AW]) && (r_tx_wr[AW-1:0] == r_tx_rd[AW-1:0]);
  assign w_rx_valid = (r_rx_wr != r_rx_rd);
  assign w_rx_full  = (r_rx_wr[AW] != r_rx_rd[AW]) && (r_rx_wr[AW-1:0] == r_rx_rd[AW-1:0]);

  assign w_tx_tick = (r_tx_cnt == BIT_LAST);
  assign w_rx_tick = (r_rx_cnt == BIT_LAST);
  assign w_tx_pop  = !w_tx_empty && ((r_tx_state == S_IDLE) || (r_tx_state == S_STOP && w_tx_tick));
  assign w_tx_flush = w_wr_fire && AWADDR[3:2] == 2'd3 && WSTRB[0] && WDATA[0];
  assign w_tx_push  = w_wr_fire && AWADDR[3:2] == 2'd1 && WSTRB[0] && (!w_tx_full || w_tx_pop);

  assign w_rx_stop_smp = (r_rx_state == S_STOP) && w_rx_tick;
  assign w_rx_flush = w_wr_fire && AWADDR[3:2] == 2'd3 && WSTRB[0] && WDATA[1];
  assign w_rx_pop   = w_rd_fire && ARADDR[3:2] == 2'd0 && w_rx_valid;
  // a pop in the same cycle frees the slot, so a full FIFO still accepts
  assign w_rx_push  = w_rx_stop_smp && r_rx_s2 && (!w_rx_full || w_rx_pop);
  assign w_ovr_set  = w_rx_stop_smp && r_rx_s2 && w_rx_full && !w_rx_pop && !w_rx_flush;
  assign w_ferr_set = w_rx_stop_smp && !r_rx_s2;
  assign w_stat_clr = w_rd_fire && ARADDR[3:2] == 2'd2;

  assign w_stat = {25'd0, r_ferr, r_ovr, w_intr_bit, w_tx_full, w_tx_empty, w_rx_full, w_rx_valid};

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_awready <= 1'b0;
      r_bvalid  <= 1'b0;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
    end else begin
      r_awready <= AWVALID && WVALID && !r_bvalid && !r_awready;
      if (w_wr_fire)   r_bvalid <= 1'b1;
      else if (BREADY) r_bvalid <= 1'b0;
      r_arready <= ARVALID && !r_rvalid && !r_arready;
      if (w_rd_fire) begin
        r_rvalid <= 1'b1;
        case (ARADDR[3:2])
          2'd0:    r_rdata <= w_rx_valid ? {24'd0, r_rx_mem[r_rx_rd[AW-1:0]]} : '0;
          2'd2:    r_rdata <= w_stat;
          default: r_rdata <= '0;
        endcase
      end else if (RREADY) begin
        r_rvalid <= 1'b0;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (w_tx_push) r_tx_mem[r_tx_wr[AW-1:0]] <= WDATA[7:0];
    if (w_rx_push && !w_rx_flush) r_rx_mem[r_rx_wr[AW-1:0]] <= r_rx_shreg;
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_tx_wr <= '0;
      r_tx_rd <= '0;
      r_rx_wr <= '0;
      r_rx_rd <= '0;
      r_ovr   <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      if (w_tx_flush) begin
        r_tx_wr <= '0;
        r_tx_rd <= '0;
      end else begin
        if (w_tx_push) r_tx_wr <= r_tx_wr + 1'b1;
        if (w_tx_pop)  r_tx_rd <= r_tx_rd + 1'b1;
      end
      if (w_rx_flush) begin
        r_rx_wr <= '0;
        r_rx_rd <= '0;
      end else begin
        if (w_rx_push) r_rx_wr <= r_rx_wr + 1'b1;
        if (w_rx_pop)  r_rx_rd <= r_rx_rd + 1'b1;
      end
      r_ovr  <= (r_ovr  & ~w_stat_clr) | w_ovr_set;
      r_ferr <= (r_ferr & ~w_stat_clr) | w_ferr_set;
    end
  end

  // TX: the STOP exit reloads directly so consecutive frames abut
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_tx_state <= S_IDLE;
      r_tx_cnt   <= '0;
      r_tx_bitn  <= '0;
      r_tx_shreg <= '0;
      r_txd      <= 1'b1;
    end else begin
      case (r_tx_state)
        S_IDLE: begin
          r_txd    <= 1'b1;
          r_tx_cnt <= '0;
          if (w_tx_pop) begin
            r_tx_shreg <= r_tx_mem[r_tx_rd[AW-1:0]];
            r_txd      <= 1'b0;
            r_tx_state <= S_START;
          end
        end
        S_START: begin
          if (w_tx_tick) begin
            r_tx_cnt   <= '0;
            r_tx_bitn  <= '0;
            r_txd      <= r_tx_shreg[0];
            r_tx_state <= S_DATA;
          end else begin
            r_tx_cnt <= r_tx_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (w_tx_tick) begin
            r_tx_cnt <= '0;
            if (r_tx_bitn == 3'd7) begin
              r_txd      <= 1'b1;
              r_tx_state <= S_STOP;
            end else begin
              r_tx_shreg <= r_tx_shreg >> 1;
              r_txd      <= r_tx_shreg[1];
              r_tx_bitn  <= r_tx_bitn + 1'b1;
            end
          end else begin
            r_tx_cnt <= r_tx_cnt + 1'b1;
          end
        end
        default: begin
          if (w_tx_tick) begin
            r_tx_cnt <= '0;
            if (w_tx_pop) begin
              r_tx_shreg <= r_tx_mem[r_tx_rd[AW-1:0]];
              r_txd      <= 1'b0;
              r_tx_state <= S_START;
            end else begin
              r_txd      <= 1'b1;
              r_tx_state <= S_IDLE;
            end
          end else begin
            r_tx_cnt <= r_tx_cnt + 1'b1;
          end
        end
      endcase
    end
  end

  // RX: sampling points are anchored half a bit after the detected falling edge
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_rx_s1    <= 1'b1;
      r_rx_s2    <= 1'b1;
      r_rx_s3    <= 1'b1;
      r_rx_state <= S_IDLE;
      r_rx_cnt   <= '0;
      r_rx_bitn  <= '0;
      r_rx_shreg <= '0;
    end else begin
      r_rx_s1 <= RXD;
      r_rx_s2 <= r_rx_s1;
      r_rx_s3 <= r_rx_s2;
      case (r_rx_state)
        S_IDLE: begin
          r_rx_cnt <= '0;
          if (r_rx_s3 && !r_rx_s2) r_rx_state <= S_START;
        end
        S_START: begin
          if (r_rx_cnt == HALF_LAST) begin
            r_rx_cnt   <= '0;
            r_rx_bitn  <= '0;
            r_rx_state <= r_rx_s2 ? S_IDLE : S_DATA;
          end else begin
            r_rx_cnt <= r_rx_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (w_rx_tick) begin
            r_rx_cnt   <= '0;
            r_rx_shreg <= {r_rx_s2, r_rx_shreg[7:1]};
            if (r_rx_bitn == 3'd7) r_rx_state <= S_STOP;
            else                   r_rx_bitn  <= r_rx_bitn + 1'b1;
          end else begin
            r_rx_cnt <= r_rx_cnt + 1'b1;
          end
        end
        default: begin
          if (w_rx_tick) begin
            r_rx_cnt   <= '0;
            r_rx_state <= S_IDLE;
          end else begin
            r_rx_cnt <= r_rx_cnt + 1'b1;
          end
        end
      endcase
    end
  end

`ifdef UART_INTR_EN
  logic r_intr_en, r_rx_valid_d, r_tx_empty_d, r_intr;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_intr_en    <= 1'b0;
      r_rx_valid_d <= 1'b0;
      r_tx_empty_d <= 1'b1;
      r_intr       <= 1'b0;
    end else begin
      if (w_wr_fire && AWADDR[3:2] == 2'd3 && WSTRB[0]) r_intr_en <= WDATA[4];
      r_rx_valid_d <= w_rx_valid;
      r_tx_empty_d <= w_tx_empty;
      r_intr <= r_intr_en && ((w_rx_valid && !r_rx_valid_d) || (w_tx_empty && !r_tx_empty_d));
    end
  end

  assign INTERRUPT  = r_intr;
  assign w_intr_bit = r_intr_en;
`else
  assign w_intr_bit = 1'b0;
`endif

endmodule

// File: tb/tb_uart_lite_slave.sv
// Bench for uart_lite_slave: AXI-Lite master tasks, serial line driver/decoder,
// and a queue-based model of the RX/TX byte streams and status flags.
module tb_uart_lite_slave;
  localparam int unsigned CPB   = 8;
  localparam int unsigned DEPTH = 16;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic [3:0]  AWADDR = '0;
  logic        AWVALID = 1'b0;
  logic        AWREADY;
  logic [31:0] WDATA = '0;
  logic [3:0]  WSTRB = '0;
  logic        WVALID = 1'b0;
  logic        WREADY;
  logic [1:0]  BRESP;
  logic        BVALID;
  logic        BREADY = 1'b1;
  logic [3:0]  ARADDR = '0;
  logic        ARVALID = 1'b0;
  logic        ARREADY;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RVALID;
  logic        RREADY = 1'b1;
  logic        RXD = 1'b1;
  logic        TXD;
`ifdef UART_INTR_EN
  logic        INTERRUPT;
`endif

  always #5 CLK = ~CLK;

  uart_lite_slave #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
    .RXD(RXD), .TXD(TXD)
`ifdef UART_INTR_EN
    , .INTERRUPT(INTERRUPT)
`endif
  );

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  logic [7:0]  rx_q[$];
  logic [7:0]  tx_exp[$];
  logic [7:0]  tx_got[$];
  logic        m_ovr = 1'b0;
  logic        m_ferr = 1'b0;
  int unsigned mon_stop_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_stat(input logic tx_empty, input logic tx_full);
    return {25'd0, m_ferr, m_ovr, 1'b0, tx_full, tx_empty,
            rx_q.size() == DEPTH, rx_q.size() != 0};
  endfunction

  task automatic axi_write(input logic [3:0] a, input logic [31:0] d,
                           input logic [3:0] s, input int unsigned hold);
    int unsigned n;
    logic acc, bv;
    @(negedge CLK);
    AWADDR = a; WDATA = d; WSTRB = s; AWVALID = 1'b1; WVALID = 1'b1;
    n = 0;
    while (AWREADY !== 1'b1 && n < 20) begin
      @(negedge CLK);
      n++;
    end
    check("aw_accept", 32'(AWREADY), 32'd1);
    check("w_accept", 32'(WREADY), 32'd1);
    BREADY = (hold == 0);
    @(negedge CLK);
    AWVALID = 1'b0; WVALID = 1'b0;
    check("bvalid", 32'(BVALID), 32'd1);
    check("bresp", 32'(BRESP), 32'd0);
    if (hold > 0) begin
      // offer a harmless second write while the response is pending
      AWADDR = 4'h0; AWVALID = 1'b1; WVALID = 1'b1;
      acc = 1'b0; bv = 1'b1;
      for (int i = 0; i < int'(hold); i++) begin
        @(negedge CLK);
        acc = acc | AWREADY;
        bv  = bv & BVALID;
      end
      AWVALID = 1'b0; WVALID = 1'b0;
      check("hold_no_accept", 32'(acc), 32'd0);
      check("bvalid_held", 32'(bv), 32'd1);
      BREADY = 1'b1;
      @(negedge CLK);
      check("bvalid_clear", 32'(BVALID), 32'd0);
    end
  endtask

  task automatic axi_read(input logic [3:0] a, output logic [31:0] d);
    int unsigned n;
    @(negedge CLK);
    ARADDR = a; ARVALID = 1'b1;
    n = 0;
    while (ARREADY !== 1'b1 && n < 20) begin
      @(negedge CLK);
      n++;
    end
    check("ar_accept", 32'(ARREADY), 32'd1);
    @(negedge CLK);
    ARVALID = 1'b0;
    check("rvalid", 32'(RVALID), 32'd1);
    d = RDATA;
  endtask

  task automatic read_stat(input string tag, input logic tx_empty, input logic tx_full);
    logic [31:0] d;
    axi_read(4'h8, d);
    check(tag, d, exp_stat(tx_empty, tx_full));
    m_ovr = 1'b0;
    m_ferr = 1'b0;
  endtask

  task automatic read_rx(input string tag);
    logic [31:0] d, e;
    axi_read(4'h0, d);
    e = (rx_q.size() != 0) ? {24'd0, rx_q.pop_front()} : 32'd0;
    check(tag, d, e);
  endtask

  task automatic rx_frame(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      RXD = f[i];
      repeat (CPB) @(negedge CLK);
    end
    RXD = 1'b1;
    repeat (stop ? 3 : CPB) @(negedge CLK);
    if (!stop)                  m_ferr = 1'b1;
    else if (rx_q.size() < DEPTH) rx_q.push_back(b);
    else                        m_ovr = 1'b1;
  endtask

  task automatic rx_glitch();
    RXD = 1'b0;
    @(negedge CLK);
    RXD = 1'b1;
    repeat (CPB + 4) @(negedge CLK);
  endtask

  task automatic wait_tx_drain();
    int unsigned n;
    n = 0;
    while (tx_got.size() < tx_exp.size() && n < 3000) begin
      @(negedge CLK);
      n++;
    end
    repeat (CPB * 2) @(negedge CLK);
    check("tx_drain_count", 32'(tx_got.size()), 32'(tx_exp.size()));
  endtask

  // decoder for the TX line, sampling mid-bit
  initial begin
    forever begin
      @(negedge CLK);
      if (RST_N === 1'b1 && TXD === 1'b0) begin
        logic [7:0] b;
        repeat (CPB / 2) @(negedge CLK);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge CLK);
          b[i] = TXD;
        end
        repeat (CPB) @(negedge CLK);
        if (TXD !== 1'b1) mon_stop_bad++;
        tx_got.push_back(b);
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic [7:0]  b;
    logic [9:0]  fr;
    int unsigned n, op;

    // reset
    repeat (4) @(negedge CLK);
    check("rst_txd", 32'(TXD), 32'd1);
    check("rst_rvalid", 32'(RVALID), 32'd0);
    check("rst_bvalid", 32'(BVALID), 32'd0);
    check("rst_awready", 32'(AWREADY), 32'd0);
    check("rst_arready", 32'(ARREADY), 32'd0);
    check("rst_rdata", RDATA, 32'd0);
    RST_N = 1'b1;
    repeat (3) @(negedge CLK);
    check("idle_rvalid", 32'(RVALID), 32'd0);
    read_stat("stat_reset", 1'b1, 1'b0);

    // single TX byte, cycle-exact line shape
    check("tx_idle", 32'(TXD), 32'd1);
    axi_write(4'h4, 32'h0000_0055, 4'h1, 0);
    tx_exp.push_back(8'h55);
    n = 0;
    while (TXD !== 1'b0 && n < 10) begin
      @(negedge CLK);
      n++;
    end
    fr = {1'b1, 8'h55, 1'b0};
    for (int k = 0; k < 10; k++) begin
      for (int c = 0; c < int'(CPB); c++) begin
        check("tx_bit", 32'(TXD), 32'(fr[k]));
        @(negedge CLK);
      end
    end
    check("tx_after_stop", 32'(TXD), 32'd1);

    // single RX frame
    rx_frame(8'hA3, 1'b1);
    read_stat("stat_rx1", 1'b1, 1'b0);
    read_rx("rx_a3");
    read_stat("stat_rx_empty", 1'b1, 1'b0);
    read_rx("rx_empty_read");

    // overrun
    for (int i = 0; i < int'(DEPTH) + 1; i++) rx_frame(8'($urandom), 1'b1);
    read_stat("stat_overrun", 1'b1, 1'b0);
    read_stat("stat_overrun_clr", 1'b1, 1'b0);
    for (int i = 0; i < int'(DEPTH); i++) read_rx("rx_full_drain");
    read_stat("stat_drained", 1'b1, 1'b0);

    // frame error and glitch
    rx_frame(8'($urandom), 1'b0);
    read_stat("stat_ferr", 1'b1, 1'b0);
    rx_glitch();
    read_stat("stat_glitch", 1'b1, 1'b0);

    // ignored writes/reads and RX flush
    rx_frame(8'h3C, 1'b1);
    axi_write(4'h0, 32'hFFFF_FFFF, 4'hF, 0);
    axi_write(4'h8, 32'hFFFF_FFFF, 4'hF, 0);
    read_stat("stat_after_ro_writes", 1'b1, 1'b0);
    axi_read(4'h4, d);
    check("read_tx_addr", d, 32'd0);
    axi_read(4'hC, d);
    check("read_ctrl_addr", d, 32'd0);
    axi_write(4'hC, 32'h0000_0002, 4'h1, 0);
    rx_q.delete();
    read_stat("stat_rx_flush", 1'b1, 1'b0);

    // randomized RX mix
    for (int it = 0; it < 40; it++) begin
      op = $urandom_range(0, 9);
      if (op <= 3)      rx_frame(8'($urandom), 1'b1);
      else if (op == 4) rx_frame(8'($urandom), 1'b0);
      else if (op == 5) rx_glitch();
      else if (op <= 7) read_rx("rx_rand");
      else              read_stat("stat_rand", 1'b1, 1'b0);
    end
    while (rx_q.size() != 0) read_rx("rx_rand_drain");
    read_stat("stat_rand_end", 1'b1, 1'b0);

    // TX flood: the first byte leaves for the shifter at once, so 16 more fit
    wait_tx_drain();
    for (int i = 0; i < int'(DEPTH) + 2; i++) begin
      b = 8'($urandom);
      axi_write(4'h4, {24'($urandom), b}, 4'hF, (i == 0) ? 5 : 0);
      if (i <= int'(DEPTH)) tx_exp.push_back(b);
    end
    read_stat("stat_tx_full", 1'b0, 1'b1);
    wait_tx_drain();
    read_stat("stat_tx_drained", 1'b1, 1'b0);

    // strobe-less write is ignored; flush keeps only the byte in flight
    axi_write(4'h4, 32'h0000_00E7, 4'hE, 0);
    b = 8'($urandom);
    axi_write(4'h4, {24'd0, b}, 4'h1, 0);
    tx_exp.push_back(b);
    axi_write(4'h4, 32'($urandom), 4'h1, 0);
    axi_write(4'h4, 32'($urandom), 4'h1, 0);
    axi_write(4'hC, 32'h0000_0001, 4'h1, 0);
    read_stat("stat_tx_flush", 1'b1, 1'b0);
    wait_tx_drain();
    repeat (CPB * 12) @(negedge CLK);

    check("tx_count", 32'(tx_got.size()), 32'(tx_exp.size()));
    for (int i = 0; i < tx_exp.size() && i < tx_got.size(); i++)
      check("tx_byte", 32'(tx_got[i]), 32'(tx_exp[i]));
    check("tx_stop_bits", mon_stop_bad, 32'd0);

    // reset mid-frame with RX data pending
    rx_frame(8'h5A, 1'b1);
    axi_write(4'h4, 32'h0000_00C3, 4'h1, 0);
    repeat (CPB * 3) @(negedge CLK);
    RST_N = 1'b0;
    repeat (2) @(negedge CLK);
    check("midreset_txd", 32'(TXD), 32'd1);
    check("midreset_rvalid", 32'(RVALID), 32'd0);
    RST_N = 1'b1;
    rx_q.delete();
    m_ovr = 1'b0;
    m_ferr = 1'b0;
    repeat (2) @(negedge CLK);
    check("after_reset_txd", 32'(TXD), 32'd1);
    read_stat("stat_after_reset", 1'b1, 1'b0);
    read_rx("rx_after_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
